// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix-keypad scanner. Drives one column at a time, samples the
//   synchronised row returns at the end of each column dwell, locks onto a
//   column when exactly one row is high, then debounces press and release
//   against the latched row pattern. Emits a binary key index, a press /
//   repeat strobe, a held level, a release strobe and a multi-key strobe.
//
//   Ports
//     clk          system clock
//     reset        synchronous, active-high reset
//     filas_raw    asynchronous row returns (bit r = row r, high = contact)
//     columnas     one-hot column drive (bit c = column c)
//     key_code     row*COLS + col of the current / last key
//     key_valid    1-cycle strobe on debounced press and each auto-repeat
//     key_held     high from the press strobe until the release strobe
//     key_release  1-cycle strobe when the debounced release completes
//     multi_key    1-cycle strobe when a scan sample shows >1 row high
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 2**19,
  parameter int DEBOUNCE_CYCLES = 2**16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 2**24,
  parameter int REPEAT_PERIOD   = 2**22,
  parameter int CODE_W          = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   filas_raw,
  output logic [COLS-1:0]   columnas,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W   = $clog2(COLS);
  localparam int DWELL_W = $clog2(SCAN_CYCLES);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [1:0] ST_SCAN       = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  // Two-flop synchroniser on the row returns
  logic [ROWS-1:0]   sync1_q, rows_s;

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ROWS-1:0]   pat_q, pat_d;
  logic [DB_W-1:0]   stab_q, stab_d;
  logic [DB_W-1:0]   rel_q, rel_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              rep_first_q, rep_first_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic              release_q, release_d;
  logic              multi_q, multi_d;

  // Row-pattern decode
  logic [ROW_W-1:0]  sel_row;
  logic              rows_any, rows_one, row_match;
  logic              dwell_last, db_done, rel_done;
  logic [COL_W-1:0]  col_next;
  logic [CODE_W-1:0] code_at;
  logic [REP_W-1:0]  rep_target;
  logic              do_rel;

  always_comb begin
    sel_row = '0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (rows_s[r]) sel_row = ROW_W'(r);
    end
  end

  assign rows_any   = |rows_s;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
  assign rows_one   = rows_any && ((rows_s & (rows_s - ROWS'(1))) == '0);
  assign row_match  = (rows_s == pat_q);
  assign dwell_last = (dwell_q == DWELL_W'(SCAN_CYCLES - 1));
  assign db_done    = (stab_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rel_done   = (rel_q  == DB_W'(DEBOUNCE_CYCLES - 1));
  assign col_next   = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
  assign code_at    = CODE_W'(sel_row) * CODE_W'(COLS) + CODE_W'(col_q);
  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
  assign rep_target = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    pat_d       = pat_q;
    stab_d      = stab_q;
    rel_d       = rel_q;
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    code_d      = code_q;
    held_d      = held_q;
    valid_d     = 1'b0;
    release_d   = 1'b0;
    multi_d     = 1'b0;
    do_rel      = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (dwell_last) begin
          dwell_d = '0;
          if (rows_one) begin
            // Lock: column drive stays here while debouncing
            pat_d   = rows_s;
            code_d  = code_at;
            stab_d  = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d   = col_next;
            multi_d = rows_any;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!row_match) begin
          stab_d  = '0;
          dwell_d = '0;
          col_d   = col_next;
          state_d = ST_SCAN;
        end else if (db_done) begin
          valid_d     = 1'b1;
          held_d      = 1'b1;
          stab_d      = '0;
          rep_d       = '0;
          rep_first_d = 1'b1;
          state_d     = ST_HELD;
        end else begin
          stab_d = stab_q + DB_W'(1);
        end
      end

      ST_HELD: begin
        if (row_match) begin
          if (REPEAT_EN != 0) begin
            if (rep_q + REP_W'(1) == rep_target) begin
              valid_d     = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else if (rep_q != REP_W'(REP_MAX)) begin
            rep_d = rep_q + REP_W'(1);
          end
        end else if (DEBOUNCE_CYCLES <= 1) begin
          do_rel = 1'b1;
        end else begin
          // This mismatch cycle already counts as the first
          rel_d   = DB_W'(1);
          state_d = ST_RELEASE_DB;
        end
      end

      default: begin // ST_RELEASE_DB
        if (row_match) begin
          // Glitch: resume hold, repeat timing keeps its place
          rel_d   = '0;
          state_d = ST_HELD;
        end else if (rel_done) begin
          do_rel = 1'b1;
        end else begin
          rel_d = rel_q + DB_W'(1);
        end
      end
    endcase

    if (do_rel) begin
      release_d = 1'b1;
      held_d    = 1'b0;
      rel_d     = '0;
      rep_d     = '0;
      dwell_d   = '0;
      col_d     = col_next;
      state_d   = ST_SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      rows_s      <= '0;
      state_q     <= ST_SCAN;
      col_q       <= '0;
      dwell_q     <= '0;
      pat_q       <= '0;
      stab_q      <= '0;
      rel_q       <= '0;
      rep_q       <= '0;
      rep_first_q <= 1'b0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      sync1_q     <= filas_raw;
      rows_s      <= sync1_q;
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      pat_q       <= pat_d;
      stab_q      <= stab_d;
      rel_q       <= rel_d;
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      release_q   <= release_d;
      multi_q     <= multi_d;
    end
  end

  always_comb begin
    columnas        = '0;
    columnas[col_q] = 1'b1;
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = release_q;
  assign multi_key   = multi_q;

`ifndef SYNTHESIS
  a_col_onehot: assert property (@(posedge clk) $onehot(columnas));
  a_strobe_excl: assert property (@(posedge clk) $onehot0({key_valid, key_release, multi_key}));
  a_valid_held: assert property (@(posedge clk) key_valid |-> key_held);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner. Two instances: u_dut with auto-repeat, u_nr
// without. Each has a keypad model (keys bit r*4+c closes row r to column c).
// Expected strobes are queued when keys are driven; a negedge monitor pops
// and compares every strobe the instances produce.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [15:0] keys0, keys1;
  logic [3:0] filas0, filas1, col0, col1, kc0, kc1;
  logic       kv0, kh0, kr0, mk0, kv1, kh1, kr1, mk1;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    int dev;
    int kind;   // 0 valid, 1 release, 2 multi
    int code;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_CYCLES(8), .DEBOUNCE_CYCLES(16),
    .REPEAT_EN(1), .REPEAT_DELAY(64), .REPEAT_PERIOD(32)) u_dut (
    .clk(clk), .reset(reset), .filas_raw(filas0), .columnas(col0),
    .key_code(kc0), .key_valid(kv0), .key_held(kh0),
    .key_release(kr0), .multi_key(mk0));

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_CYCLES(8), .DEBOUNCE_CYCLES(16),
    .REPEAT_EN(0), .REPEAT_DELAY(64), .REPEAT_PERIOD(32)) u_nr (
    .clk(clk), .reset(reset), .filas_raw(filas1), .columnas(col1),
    .key_code(kc1), .key_valid(kv1), .key_held(kh1),
    .key_release(kr1), .multi_key(mk1));

  // Keypad matrix: a row reads high when a closed key sits on the driven column
  always_comb begin
    filas0 = '0;
    filas1 = '0;
    for (int r = 0; r < 4; r++) begin
      filas0[r] = |(keys0[r*4 +: 4] & col0);
      filas1[r] = |(keys1[r*4 +: 4] & col1);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic m,
                     input logic [3:0] code);
    int k;
    ev_t e;
    if (v || r || m) begin
      chk("strobe_excl", int'(v) + int'(r) + int'(m), 1);
      k = v ? 0 : (r ? 1 : 2);
      if (sb.size() == 0) begin
        chk("unexpected_strobe_kind", k, -1);
      end else begin
        e = sb.pop_front();
        chk("sb_dev", d, e.dev);
        chk("sb_kind", k, e.kind);
        if (k != 2) chk("sb_code", int'(code), e.code);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, kv0, kr0, mk0, kc0);
    mon(1, kv1, kr1, mk1, kc1);
  end

  task automatic push(input int dev, input int kind, input int code);
    ev_t e;
    e.dev = dev; e.kind = kind; e.code = code;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a strobe; t = edge count at which it became visible
  task automatic wait_strobe(input int dev, input int kind, input int max, output int t);
    logic hit;
    t = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      case (kind)
        0:       hit = dev ? kv1 : kv0;
        1:       hit = dev ? kr1 : kr0;
        default: hit = dev ? mk1 : mk0;
      endcase
      if (hit) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk($sformatf("timeout_d%0d_k%0d", dev, kind), t, 0);
  endtask

  // Returns the edge count of the first edge after reset is released
  task automatic do_reset(input int n, output int e0);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, t, p, p2, p3, rr;
    reset = 1'b1;
    keys0 = '0;
    keys1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_col0", col0, 1);
    chk("rst_code0", kc0, 0);
    chk("rst_strobes0", {kv0, kh0, kr0, mk0}, 0);
    chk("rst_col1", col1, 1);
    chk("rst_strobes1", {kv1, kh1, kr1, mk1}, 0);

    // Idle scan: each column held for 8 cycles
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("idle_col_%0d", k), col0, 1 << (k % 4));
      repeat (7) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    // Clean press row 2 / col 1 -> code 9, repeats at +64 and +96
    push(0, 0, 9); push(0, 0, 9); push(0, 0, 9);
    rr = cyc;
    keys0[9] = 1'b1;
    wait_strobe(0, 0, 100, p);
    chk("press_lat_in_window", int'((p - rr) >= 19 && (p - rr) <= 50), 1);
    chk("held_on_press", kh0, 1);
    wait_strobe(0, 0, 100, p2);
    chk("repeat_delay", p2 - p, 64);
    wait_strobe(0, 0, 100, p3);
    chk("repeat_period", p3 - p2, 32);
    while (cyc < p + 110) @(negedge clk);
    push(0, 1, 9);
    rr = cyc;
    keys0 = '0;
    wait_strobe(0, 1, 60, t);
    chk("release_lat", t - rr, 18);
    chk("held_after_release", kh0, 0);
    chk("code_retained", kc0, 9);

    // Bounce row 0 / col 3: toggling every 5 cycles must not strobe
    for (int i = 0; i < 12; i++) begin
      keys0[3] = ~keys0[3];
      repeat (5) @(negedge clk);
    end
    push(0, 0, 3);
    keys0[3] = 1'b1;
    wait_strobe(0, 0, 100, t);
    chk("bounce_code", kc0, 3);
    push(0, 1, 3);
    keys0 = '0;
    wait_strobe(0, 1, 60, t);

    // Rows 1 and 3 on column 0: multi_key on each column-0 sample
    do_reset(2, e0);
    push(0, 2, 0); push(0, 2, 0); push(0, 2, 0); push(0, 2, 0);
    keys0[4]  = 1'b1;
    keys0[12] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(0, 2, 60, t);
      chk($sformatf("multi_time_%0d", i), t - e0, 8 + 32 * i);
    end
    while (cyc < e0 + 110) @(negedge clk);
    keys0 = '0;
    repeat (40) @(negedge clk);

    // No auto-repeat: single strobe over a long hold with a 5-cycle glitch
    push(1, 0, 2);
    keys1[2] = 1'b1;
    wait_strobe(1, 0, 100, t);
    repeat (100) @(negedge clk);
    keys1[2] = 1'b0;
    repeat (5) @(negedge clk);
    keys1[2] = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_held", kh1, 1);
    repeat (170) @(negedge clk);
    push(1, 1, 2);
    keys1 = '0;
    wait_strobe(1, 1, 60, t);
    chk("nr_held_after_release", kh1, 0);

    // Reset 3 cycles after press strobe; press re-debounced from zero
    push(0, 0, 15);
    keys0[15] = 1'b1;
    wait_strobe(0, 0, 100, p);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    e0 = cyc;
    @(negedge clk);
    chk("midrst_col", col0, 1);
    chk("midrst_code", kc0, 0);
    chk("midrst_outs", {kv0, kh0, kr0, mk0}, 0);
    push(0, 0, 15);
    wait_strobe(0, 0, 100, t);
    chk("repress_time", t - e0, 48);
    push(0, 1, 15);
    keys0 = '0;
    wait_strobe(0, 1, 60, t);
    repeat (20) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner. It drives one column at a time, synchronises and debounces the row returns, and emits a binary key index with a one-cycle press strobe. It also provides held and release indications, multi-key rejection and optional auto-repeat. It sits between the keypad pins and the key-decoding logic, replacing the fixed 4x4 column FSM plus per-row debouncers with a single locked-column state machine.

Parameters:
ROWS, 4, number of row inputs (>=1)
COLS, 4, number of column drive outputs (>=2)
SCAN_CYCLES, 2**19, clock cycles each column is driven while scanning (>=4)
DEBOUNCE_CYCLES, 2**16, consecutive stable cycles required for press and for release (>=1)
REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = single strobe per press
REPEAT_DELAY, 2**24, cycles from the press strobe to the first repeat strobe
REPEAT_PERIOD, 2**22, cycles between subsequent repeat strobes
CODE_W, $clog2(ROWS*COLS), key index width (derived; do not override)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
filas_raw  in  ROWS  asynchronous row returns; bit r = row r; high = contact to the driven column
columnas  out  COLS  one-hot column drive; bit c = column c
key_code  out  CODE_W  index of the current or last key = row*COLS + col
key_valid  out  1  one-cycle strobe on a debounced press and on each repeat
key_held  out  1  high from the press strobe until the release strobe
key_release  out  1  one-cycle strobe when the debounced release completes
multi_key  out  1  one-cycle strobe when a scan sample has more than one row high

Behaviour:
- Reset values: columnas = 1 (column 0), key_code = 0, key_valid/key_held/key_release/multi_key = 0, state = SCAN, all counters 0, synchroniser flops 0.
- filas_raw passes through a 2-flop synchroniser; rows_s denotes the synchronised value (2-cycle latency). All decisions use rows_s.
- Index arithmetic: key_code = row*COLS + col computed at CODE_W bits; col wraps from COLS-1 to 0.
- SCAN state:
  - Dwell counter runs 0..SCAN_CYCLES-1 per column. rows_s is sampled only on the last dwell cycle, which allows settling plus synchroniser latency.
  - Zero rows high at the sample: advance to the next column and clear the dwell counter.
  - Exactly one row high: latch row/col and the row pattern, load key_code, go to DEBOUNCE. columnas stays on the locked column.
  - More than one row high: pulse multi_key on the next cycle, advance the column, no capture.
- DEBOUNCE state:
  - Each cycle rows_s equals the latched pattern, increment the stable counter; any mismatch returns to SCAN on the next column.
  - When the counter reaches DEBOUNCE_CYCLES: pulse key_valid for 1 cycle, set key_held, clear the repeat counter, go to HELD.
- HELD state:
  - rows_s matches: the repeat counter runs. If REPEAT_EN=1, pulse key_valid when the counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that. key_code is unchanged.
  - rows_s mismatches (a different or an additional row counts as mismatch): go to RELEASE_DB with the release counter at 1.
- RELEASE_DB state:
  - Counts consecutive mismatch cycles. A match returns to HELD; the repeat counter is held, not cleared.
  - When the count reaches DEBOUNCE_CYCLES: pulse key_release, clear key_held, go to SCAN on the column after the locked one. key_code retains the last value.
- Strobes are mutually exclusive in any cycle. key_valid is never asserted while key_held=0 except on the press cycle itself, where key_held rises in the same cycle.
- Reset asserted mid-operation: next cycle all outputs and state return to their reset values. A pending strobe is dropped; no release strobe is generated.
- Counter widths are sized by $clog2 of their terminal values. No counter wraps silently; every counter saturates or clears on its state transition.

Test Plan:
(Overrides: ROWS=4, COLS=4, SCAN_CYCLES=8, DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_PERIOD=32.)
- Idle with rows=0 for 80 cycles -> columnas cycles 1,2,4,8,1 every 8 cycles; no strobes.
- Clean press row 2 / col 1, held 200 cycles then released -> key_valid at press+16 with key_code=9, key_held=1, repeats at +64 and +96. After release, key_release 16 cycles later and key_held=0.
- Bounce row 0 / col 3 by toggling every 5 cycles for 60 cycles, then stable -> no strobe during the toggling; exactly one key_valid with code 3 after 16 stable cycles.
- Rows 1 and 3 high on column 0 -> multi_key pulse once per column-0 visit; key_valid never asserts.
- REPEAT_EN=0, key held 300 cycles -> exactly one key_valid. Release glitch of 5 cycles mid-hold -> no key_release; key_held stays 1.
- Reset pulsed 3 cycles after the press strobe -> all outputs 0 and columnas=1 next cycle; the following press is re-debounced from zero.
